jk_updown_counter: RTL and testbench
====================================

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and cl.
REQ-002 Port clk  input  1  rising-edge clock; all state changes except clear occur on this edge.
REQ-003 Port cl  input  1  asynchronous active-low clear.
REQ-004 Port en  input  1  count enable; when high, the counter steps once per clk edge.
REQ-005 Port up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
REQ-006 Port ld  input  1  synchronous load; takes priority over en.
REQ-007 Port din  input  4  load value.
REQ-008 Port maxv  input  4  wrap limit; the count range is 0..maxv inclusive.
REQ-009 Port q  output  4  count value, taken directly from the stage flops.
REQ-010 Port qb  output  4  bitwise complement of q at all times, including during clear.
REQ-011 Port tc  output  1  combinational terminal count: (up=1 and q==maxv) or (up=0 and q==0).
REQ-012 Port wrap  output  1  registered one-cycle pulse.
REQ-013 wrap SHALL be high in the cycle after an enabled step that wrapped the count.

Function
REQ-014 Each clk edge SHALL perform exactly one action, in priority order: ld, then en, then hold.
REQ-015 With ld=1, q SHALL become din if din<=maxv, and maxv otherwise (clamp); wrap SHALL be 0.
REQ-016 With ld=0, en=1, up=1, q SHALL become q+1 if q<maxv, and 0 otherwise.
REQ-017 With ld=0, en=1, up=0, q SHALL become q-1 if 0<q<=maxv, and maxv if q==0.
REQ-018 If q>maxv (maxv lowered at run time) and en=1, q SHALL become 0 when up=1 and maxv when up=0; wrap SHALL be 1.
REQ-019 wrap SHALL be 1 in the cycle after a step taken by REQ-016 second branch, REQ-017 second branch or REQ-018, and 0 otherwise.
REQ-020 With ld=0 and en=0, q SHALL hold and wrap SHALL be 0.
REQ-021 With maxv=0 and en=1, q SHALL stay 0 and wrap SHALL pulse every enabled cycle in both directions.
REQ-022 Each bit SHALL be stored in one JK stage. Excitation per bit: hold j=0 k=0; load j=d k=~d; count j=k=toggle_i.
REQ-023 toggle_i SHALL equal q_i XOR next_i, so that wrap and clamp cases also use toggle-only excitation.
REQ-024 Latency SHALL be one clk edge from inputs to q. tc SHALL have zero latency from q, up and maxv.
REQ-025 The block SHALL contain no combinational path from din, ld or en to q, qb or wrap.

Reset
REQ-026 While cl=0, q SHALL be 4'h0, qb SHALL be 4'hF and wrap SHALL be 0, immediately and regardless of clk.
REQ-027 A clear asserted mid-count SHALL abort the step, with no partial update and no wrap pulse afterwards.
REQ-028 On cl release, the first action SHALL occur at the next rising clk edge, using the inputs sampled at that edge.

Structure
REQ-029 A shared package SHALL hold CNT_W=4 and the JK action encoding: HOLD=00, RESET=01, SET=10, TOGGLE=11.
REQ-030 Submodule jk_stage SHALL be one JK flip-flop with q/qb and asynchronous active-low clear.
REQ-031 jk_stage SHALL be instantiated CNT_W times. Excitation logic and the wrap register SHALL live in the parent.

Verification
REQ-032 cl=0 for 100 ns, then released -> q=0, qb=F, wrap=0 throughout.
REQ-033 Scenario: maxv=9, up=1, en=1 for 12 cycles -> q reads 1..9,0,1,2; wrap high only in the cycle after 9->0; tc high while q=9.
REQ-034 Scenario: maxv=9, q=0, up=0, en=1 -> q=9 with a wrap pulse, then 8,7.
REQ-035 Scenario: ld=1, din=C, maxv=9 -> q=9.
REQ-036 Scenario: ld=1 and en=1 together with din=3 -> q=3, wrap=0.
REQ-037 Scenario: at q=5 lower maxv to 3, up=1, en=1 -> q=0 with a wrap pulse.
REQ-038 Scenario: cl pulsed low mid-cycle during counting -> q=0 at once; the next edge after release counts from 0.

Source files
------------

// File: rtl/jk_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_updown_counter_pkg
// Purpose  : Shared width, JK action encoding and small helpers for the
//            JK-based up/down wrap counter.
// Revision : 1.0 - initial release
// ============================================================================
package jk_updown_counter_pkg;

  localparam int CNT_W = 4;

  // Action encoding is {j,k}, so the enum value drives the stage pins directly.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_action_e;

  // Split an action into its {j,k} pin pair.
  function automatic logic [1:0] jk_pins(input jk_action_e act);
    logic [1:0] pins;
    pins = act;
    return pins;
  endfunction

  // Load value limited to the active count range 0..maxv.
  function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] din,
                                                  input logic [CNT_W-1:0] maxv);
    return (din <= maxv) ? din : maxv;
  endfunction

endpackage : jk_updown_counter_pkg
`default_nettype wire

// File: rtl/jk_updown_counter_stage.sv
`default_nettype none
// ============================================================================
// Module   : jk_stage
// Purpose  : Single JK flip-flop with complementary output and asynchronous
//            active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module jk_stage (
  input  logic clk,
  input  logic cl,
  input  logic j_i,
  input  logic k_i,
  output logic q_o,
  output logic qb_o
);

  logic q_q;

  // JK storage: hold, reset, set or toggle on the rising edge; clear wins.
  always_ff @(posedge clk or negedge cl) begin
    if (!cl) begin
      q_q <= 1'b0;
    end else begin
      unique case ({j_i, k_i})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign q_o  = q_q;
  // Complement is taken from the flop itself, so it reads all-ones during clear.
  assign qb_o = ~q_q;

endmodule : jk_stage
`default_nettype wire

// File: rtl/jk_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : jk_updown_counter
// Purpose  : Up/down counter over 0..maxv built from JK stages, with clamped
//            synchronous load, terminal count and a registered wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module jk_updown_counter
  import jk_updown_counter_pkg::*;
(
  input  logic             clk,
  input  logic             cl,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [CNT_W-1:0] din,
  input  logic [CNT_W-1:0] maxv,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cntb_q;
  logic [CNT_W-1:0] next_d;
  logic [CNT_W-1:0] toggle_d;
  logic [CNT_W-1:0] j_d;
  logic [CNT_W-1:0] k_d;
  logic             wrap_d;
  logic             wrap_q;
  jk_action_e       act_d [CNT_W];

  // Next count value and wrap flag, in priority order load > count > hold.
  always_comb begin
    next_d = cnt_q;
    wrap_d = 1'b0;
    if (ld) begin
      next_d = clamp_load(din, maxv);
    end else if (en) begin
      if (up) begin
        // q==maxv and an out-of-range q (maxv lowered) both wrap to zero.
        if (cnt_q < maxv) begin
          next_d = cnt_q + 1'b1;
        end else begin
          next_d = '0;
          wrap_d = 1'b1;
        end
      end else begin
        // q==0 and an out-of-range q both wrap to maxv.
        if ((cnt_q != '0) && (cnt_q <= maxv)) begin
          next_d = cnt_q - 1'b1;
        end else begin
          next_d = maxv;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // Counting uses toggle-only excitation, including wrap and out-of-range cases.
  assign toggle_d = cnt_q ^ next_d;

  // Per-bit JK action: load forces each bit, count toggles, otherwise hold.
  always_comb begin
    for (int i = 0; i < CNT_W; i++) begin
      act_d[i] = JK_HOLD;
      if (ld) begin
        act_d[i] = next_d[i] ? JK_SET : JK_RESET;
      end else if (en) begin
        act_d[i] = toggle_d[i] ? JK_TOGGLE : JK_HOLD;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_stage
      assign {j_d[gi], k_d[gi]} = jk_pins(act_d[gi]);

      jk_stage u_stage (
        .clk  (clk),
        .cl   (cl),
        .j_i  (j_d[gi]),
        .k_i  (k_d[gi]),
        .q_o  (cnt_q[gi]),
        .qb_o (cntb_q[gi])
      );
    end
  endgenerate

  // Wrap pulse follows the step that wrapped; clear suppresses any pending pulse.
  always_ff @(posedge clk or negedge cl) begin
    if (!cl) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign qb   = cntb_q;
  assign wrap = wrap_q;
  assign tc   = up ? (cnt_q == maxv) : (cnt_q == '0);

endmodule : jk_updown_counter
`default_nettype wire

// File: tb/tb_jk_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_updown_counter
// Purpose  : Self-checking bench for jk_updown_counter: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_updown_counter;

  logic       clk;
  logic       cl;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] din;
  logic [3:0] maxv;
  logic [3:0] q;
  logic [3:0] qb;
  logic       tc;
  logic       wrap;

  int n_checks;
  int n_pass;

  // Reference state
  int m_q;
  int m_wrap;

  jk_updown_counter dut (
    .clk  (clk),
    .cl   (cl),
    .en   (en),
    .up   (up),
    .ld   (ld),
    .din  (din),
    .maxv (maxv),
    .q    (q),
    .qb   (qb),
    .tc   (tc),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Compare every output against the model.
  task automatic check_all(input string tag);
    int exp_tc;
    exp_tc = up ? (m_q == int'(maxv)) : (m_q == 0);
    check({tag, ".q"},    {4'h0, q},    8'(m_q));
    check({tag, ".qb"},   {4'h0, qb},   8'(15 - m_q));
    check({tag, ".wrap"}, {7'h0, wrap}, 8'(m_wrap));
    check({tag, ".tc"},   {7'h0, tc},   8'(exp_tc));
  endtask

  // Model of one clock edge, written from the counting rules.
  task automatic model_edge();
    int mx;
    mx = int'(maxv);
    m_wrap = 0;
    if (ld) begin
      m_q = (int'(din) > mx) ? mx : int'(din);
    end else if (en) begin
      if (up) begin
        if (m_q < mx) m_q = m_q + 1;
        else begin m_q = 0; m_wrap = 1; end
      end else begin
        if (m_q > 0 && m_q <= mx) m_q = m_q - 1;
        else begin m_q = mx; m_wrap = 1; end
      end
    end
  endtask

  // One edge: model sees the inputs present at the edge, outputs sampled 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic l, input logic e, input logic u,
                       input logic [3:0] d, input logic [3:0] m);
    ld = l; en = e; up = u; din = d; maxv = m;
  endtask

  // Pulse clear between edges; outputs must react without a clock.
  task automatic mid_clear(input string tag);
    #2;
    cl = 1'b0;
    #1;
    m_q = 0;
    m_wrap = 0;
    check_all(tag);
    #1;
    cl = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_q      = 0;
    m_wrap   = 0;
    cl = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 4'h5, 4'h9);

    // Held in clear for 100 ns with enable active.
    for (int i = 0; i < 5; i++) begin
      #20;
      check_all("reset");
    end
    @(negedge clk);
    cl = 1'b1;

    // Count up 0..9 and wrap.
    drive(1'b1, 1'b0, 1'b1, 4'h0, 4'h9);
    step("ld0");
    drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h9);
    for (int i = 0; i < 12; i++) step("up9");
    check("up9.final", {4'h0, q}, 8'h2);

    // Count down from 0 wraps to 9.
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h9);
    step("ld0b");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h9);
    step("dn_wrap");
    check("dn_wrap.pulse", {7'h0, wrap}, 8'h1);
    step("dn8");
    step("dn7");
    check("dn7.val", {4'h0, q}, 8'h7);

    // Clamped load.
    drive(1'b1, 1'b0, 1'b1, 4'hC, 4'h9);
    step("ld_clamp");
    check("ld_clamp.val", {4'h0, q}, 8'h9);

    // Load beats enable.
    drive(1'b1, 1'b1, 1'b1, 4'h3, 4'h9);
    step("ld_en");

    // Lowering maxv below q wraps on the next enabled step.
    drive(1'b1, 1'b0, 1'b1, 4'h5, 4'h9);
    step("ld5");
    drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h3);
    step("maxv_drop");
    check("maxv_drop.pulse", {7'h0, wrap}, 8'h1);

    // maxv=0: stays zero, wraps every enabled cycle both ways.
    drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    step("m0_up");
    step("m0_up");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    step("m0_dn");

    // Hold.
    drive(1'b1, 1'b0, 1'b1, 4'h6, 4'hF);
    step("ld6");
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'hF);
    step("hold");

    // Clear mid-count, then resume from zero.
    drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h9);
    step("pre_clr");
    step("pre_clr");
    mid_clear("mid_clr");
    step("post_clr");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom_range(0, 1));
      din = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) maxv = 4'($urandom_range(0, 15));
      step("rand");
      if ($urandom_range(0, 49) == 0) mid_clear("rand_clr");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_jk_updown_counter
`default_nettype wire
